// File: rtl/fft_pkg.sv
// Shared definitions for the row/column FFT datapath: default sizes and the
// transpose-buffer bank state encoding.
package fft_pkg;

  localparam int WL_DEF     = 10;
  localparam int N_DEF      = 80;
  localparam int ADDR_W_DEF = $clog2(N_DEF * N_DEF);
  localparam int CNT_W_DEF  = $clog2(N_DEF);

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

endpackage

// File: rtl/tp_ram.sv
// Simple dual-port frame store: two banks of N*N words, one write port and
// one synchronous read port whose output holds while rd_en is low.
module tp_ram
  import fft_pkg::*;
#(
  parameter int W  = 2 * WL_DEF,
  parameter int N  = N_DEF,
  parameter int AW = $clog2(N * N)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW:0]   wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW:0]   rd_addr,
  output logic [W-1:0]  rd_data
);

  // Address MSB selects the bank; the rest is the word within the frame.
  logic [W-1:0] mem [2][N*N];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[AW]][wr_addr[AW-1:0]] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr[AW]][rd_addr[AW-1:0]];
  end

endmodule

// File: rtl/transpose_buffer.sv
// Ping-pong corner-turn buffer between the row FFT and the column FFT:
// frames are written row-major into one bank while the other is read column-major.
module transpose_buffer
  import fft_pkg::*;
#(
  parameter int WL = WL_DEF,
  parameter int N  = N_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [WL-1:0]   in_r,
  input  logic [WL-1:0]   in_i,
  output logic            in_ready,
  output logic [2*WL-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            overflow
);

  localparam int AW = $clog2(N * N);
  localparam int CW = $clog2(N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N * N - 1);
  localparam logic [AW-1:0] STEP      = AW'(N);
  localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);

  bank_state_t     bank_state [2];
  bank_state_t     bank_nxt   [2];
  logic            wr_bank, rd_bank, iss_bank;
  logic [AW-1:0]   wr_cnt;
  logic [CW-1:0]   iss_r, iss_c;
  logic [AW-1:0]   iss_addr;
  logic            iss_active, rd_pend, pend_last;
  logic            wr_en, load, can_issue, iss_en, iss_last, drain_done;
  logic [2*WL-1:0] ram_rd_data;

  // Handshakes: a word moves on a port only in a cycle where valid and ready
  // are both high; while valid && !ready the producer holds data stable.
  assign in_ready = (bank_state[wr_bank] == BANK_EMPTY) ||
                    (bank_state[wr_bank] == BANK_FILLING);

  // The RAM output acts as a one-deep prefetch stage: a read is issued only
  // when the word already sitting there is leaving this cycle, so the next
  // frame can start issuing while the previous frame's tail drains.
  always_comb begin
    wr_en      = in_valid && in_ready;
    load       = !out_valid || out_ready;
    can_issue  = !rd_pend || load;
    iss_en     = can_issue && (iss_active || bank_state[iss_bank] == BANK_FULL);
    iss_last   = (iss_r == LAST_IDX) && (iss_c == LAST_IDX);
    drain_done = out_valid && out_ready && out_last;
  end

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_nxt[b] = bank_state[b];
      if (wr_en && wr_bank == 1'(b))
        bank_nxt[b] = (wr_cnt == LAST_ADDR) ? BANK_FULL : BANK_FILLING;
      if (iss_en && !iss_active && iss_bank == 1'(b))
        bank_nxt[b] = BANK_DRAINING;
      if (drain_done && rd_bank == 1'(b))
        bank_nxt[b] = BANK_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_state <= '{default: BANK_EMPTY};
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      iss_bank   <= 1'b0;
      wr_cnt     <= '0;
      iss_r      <= '0;
      iss_c      <= '0;
      iss_addr   <= '0;
      iss_active <= 1'b0;
      rd_pend    <= 1'b0;
      pend_last  <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      bank_state <= bank_nxt;
      if (in_valid && !in_ready) overflow <= 1'b1;

      if (wr_en) begin
        if (wr_cnt == LAST_ADDR) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + AW'(1);
        end
      end

      // Column-major walk: step by N down a column, jump to the next column top.
      if (iss_en) begin
        pend_last <= iss_last;
        if (iss_last) begin
          iss_active <= 1'b0;
          iss_bank   <= ~iss_bank;
          iss_r      <= '0;
          iss_c      <= '0;
          iss_addr   <= '0;
        end else begin
          iss_active <= 1'b1;
          if (iss_r == LAST_IDX) begin
            iss_r    <= '0;
            iss_c    <= iss_c + CW'(1);
            iss_addr <= AW'(iss_c) + AW'(1);
          end else begin
            iss_r    <= iss_r + CW'(1);
            iss_addr <= iss_addr + STEP;
          end
        end
      end

      if (iss_en)    rd_pend <= 1'b1;
      else if (load) rd_pend <= 1'b0;

      if (load) begin
        out_valid <= rd_pend;
        out_last  <= rd_pend && pend_last;
        if (rd_pend) out_data <= ram_rd_data;
      end

      if (drain_done) rd_bank <= ~rd_bank;
    end
  end

  tp_ram #(
    .W  (2 * WL),
    .N  (N),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_cnt}),
    .wr_data ({in_r, in_i}),
    .rd_en   (iss_en),
    .rd_addr ({iss_bank, iss_addr}),
    .rd_data (ram_rd_data)
  );

endmodule

// File: tb/tb_transpose_buffer.sv
// Bench for transpose_buffer: a 4x4 instance for cycle-exact corner cases and
// an 80x80 instance for full-size frames with burst writes and reset mid-frame.
module tb_transpose_buffer;

  logic clk;

  // 4x4 instance
  logic       rst4, in_valid4, in_ready4, out_valid4, out_ready4, out_last4, overflow4;
  logic [9:0] in_r4, in_i4;
  logic [19:0] out_data4;

  // 80x80 instance
  logic       rst80, in_valid80, in_ready80, out_valid80, out_ready80, out_last80, overflow80;
  logic [9:0] in_r80, in_i80;
  logic [19:0] out_data80;

  int total;
  int bad;
  logic [20:0] exp_q[$];

  typedef struct {
    logic        in_valid;
    logic [9:0]  in_r;
    logic [9:0]  in_i;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_valid;
    logic        exp_last;
    logic [19:0] exp_data;
  } vec_t;

  vec_t vecs[34];

  transpose_buffer #(.WL(10), .N(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_r(in_r4), .in_i(in_i4),
    .in_ready(in_ready4), .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_last(out_last4), .overflow(overflow4)
  );

  transpose_buffer #(.WL(10), .N(80)) dut80 (
    .clk(clk), .rst(rst80), .in_valid(in_valid80), .in_r(in_r80), .in_i(in_i80),
    .in_ready(in_ready80), .out_data(out_data80), .out_valid(out_valid80),
    .out_ready(out_ready80), .out_last(out_last80), .overflow(overflow80)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- drivers (called at posedge+2, return at posedge+2) ----------------
  task automatic wr4(input logic [9:0] r, input logic [9:0] i);
    in_valid4 = 1'b1;
    in_r4     = r;
    in_i4     = i;
    @(posedge clk);
    #2;
    in_valid4 = 1'b0;
  endtask

  task automatic wr80(input int base, input int nburst);
    logic [19:0] v;
    for (int b = 0; b < nburst; b++) begin
      for (int j = 0; j < 16; j++) begin
        v          = 20'(base + b * 16 + j);
        in_valid80 = 1'b1;
        in_r80     = v[19:10];
        in_i80     = v[9:0];
        @(posedge clk);
        #2;
      end
      in_valid80 = 1'b0;
      repeat (24) @(posedge clk);
      #2;
    end
  endtask

  // Consume up to n outputs of dut80 against exp_q with random backpressure.
  task automatic drain80(input int n, input int budget, output int n_out);
    logic [20:0] e;
    int cyc;
    n_out = 0;
    cyc   = 0;
    while (n_out < n && cyc < budget) begin
      @(posedge clk);
      #2;
      out_ready80 = ($urandom_range(0, 7) != 0);
      @(negedge clk);
      if (out_valid80 && out_ready80) begin
        if (exp_q.size() == 0) begin
          check("t80_unexpected_out", {11'd0, out_last80, out_data80}, 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("t80_out[%0d]", n_out), {11'd0, out_last80, out_data80}, {11'd0, e});
        end
        n_out++;
      end
      cyc++;
    end
    @(posedge clk);
    #2;
    out_ready80 = 1'b0;
  endtask

  // Expected column-major order of an 80x80 frame whose sample s holds base+s.
  task automatic push_frame80(input int base);
    for (int k = 0; k < 6400; k++)
      exp_q.push_back({k == 6399, 20'(base + (k % 80) * 80 + k / 80)});
  endtask

  task automatic run80(input int nfr, input int base);
    int n_out;
    exp_q.delete();
    for (int f = 0; f < nfr; f++) push_frame80(base + f * 6400);
    fork
      begin
        for (int f = 0; f < nfr; f++) wr80(base + f * 6400, 400);
      end
      begin
        drain80(nfr * 6400, nfr * 16000 + 12000, n_out);
      end
    join
    check("t80_count", 32'(n_out), 32'(nfr * 6400));
    check("t80_overflow", {31'd0, overflow80}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k, cyc, w, t15, t16, n_out, kk, f;
    logic pv, pl;
    logic [19:0] pd;
    int pat[4];

    total = 0;
    bad   = 0;
    pat   = '{1, 0, 0, 1};
    rst4 = 1'b1; in_valid4 = 1'b0; in_r4 = '0; in_i4 = '0; out_ready4 = 1'b1;
    rst80 = 1'b1; in_valid80 = 1'b0; in_r80 = '0; in_i80 = '0; out_ready80 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst4  = 1'b0;
    rst80 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Idle after reset
    check("rst4_out_valid", {31'd0, out_valid4}, 32'd0);
    check("rst4_in_ready", {31'd0, in_ready4}, 32'd1);
    check("rst4_out_data", {12'd0, out_data4}, 32'd0);
    check("rst4_overflow", {31'd0, overflow4}, 32'd0);
    check("rst4_out_last", {31'd0, out_last4}, 32'd0);
    check("rst80_out_valid", {31'd0, out_valid80}, 32'd0);
    check("rst80_in_ready", {31'd0, in_ready80}, 32'd1);
    check("rst80_out_data", {12'd0, out_data80}, 32'd0);
    check("rst80_overflow", {31'd0, overflow80}, 32'd0);
    #1;

    // 4x4 frame 0..15 with out_ready=1: write on vectors 0..15, bank FULL after
    // vector 15, first output visible after vector 17, last after vector 32.
    for (int i = 0; i < 34; i++) begin
      k = i - 17;
      w = (k >= 0) ? (k % 4) * 4 + k / 4 : 0;
      vecs[i].in_valid     = (i < 16);
      vecs[i].in_r         = 10'(i);
      vecs[i].in_i         = 10'(10'h300 ^ 10'(i));
      vecs[i].out_ready    = 1'b1;
      vecs[i].exp_in_ready = 1'b1;
      vecs[i].exp_valid    = (i >= 17) && (i <= 32);
      vecs[i].exp_last     = (i == 32);
      vecs[i].exp_data     = {10'(w), 10'(10'h300 ^ 10'(w))};
    end
    for (int i = 0; i < 34; i++) begin
      in_valid4  = vecs[i].in_valid;
      in_r4      = vecs[i].in_r;
      in_i4      = vecs[i].in_i;
      out_ready4 = vecs[i].out_ready;
      @(posedge clk);
      #1;
      check($sformatf("vec[%0d]_in_ready", i), {31'd0, in_ready4}, {31'd0, vecs[i].exp_in_ready});
      check($sformatf("vec[%0d]_out_valid", i), {31'd0, out_valid4}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec[%0d]_out_last", i), {31'd0, out_last4}, {31'd0, vecs[i].exp_last});
      if (vecs[i].exp_valid)
        check($sformatf("vec[%0d]_out_data", i), {12'd0, out_data4}, {12'd0, vecs[i].exp_data});
      #1;
    end
    in_valid4 = 1'b0;

    // 4x4 frame with out_ready pattern 1,0,0,1 (lands in the second bank)
    out_ready4 = 1'b0;
    for (int i = 0; i < 16; i++) wr4(10'(40 + i), 10'(10'h155 ^ 10'(i)));
    k   = 0;
    cyc = 0;
    while (k < 16 && cyc < 200) begin
      out_ready4 = pat[cyc % 4][0];
      pv = out_valid4;
      pd = out_data4;
      pl = out_last4;
      @(posedge clk);
      #1;
      if (pv && !out_ready4) begin
        check("stall_data", {12'd0, out_data4}, {12'd0, pd});
        check("stall_valid", {31'd0, out_valid4}, 32'd1);
        check("stall_last", {31'd0, out_last4}, {31'd0, pl});
      end else if (pv) begin
        w = (k % 4) * 4 + k / 4;
        check($sformatf("bp_out[%0d]", k), {11'd0, pl, pd},
              {11'd0, k == 15, 10'(40 + w), 10'(10'h155 ^ 10'(w))});
        k++;
      end
      #1;
      cyc++;
    end
    check("bp_count", 32'(k), 32'd16);
    out_ready4 = 1'b1;

    // 4x4 overflow: out_ready=0, stream 48 samples
    rst4 = 1'b1;
    @(posedge clk);
    #2;
    rst4       = 1'b0;
    out_ready4 = 1'b0;
    for (int s = 0; s < 48; s++) begin
      in_valid4 = 1'b1;
      in_r4     = 10'(200 + s);
      in_i4     = 10'(s);
      @(posedge clk);
      #1;
      check($sformatf("ovf_in_ready[%0d]", s), {31'd0, in_ready4}, {31'd0, s < 31});
      check($sformatf("ovf_flag[%0d]", s), {31'd0, overflow4}, {31'd0, s >= 32});
      #1;
    end
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    k   = 0;
    cyc = 0;
    t15 = 0;
    t16 = 0;
    while (k < 32 && cyc < 200) begin
      pv = out_valid4;
      pd = out_data4;
      pl = out_last4;
      @(posedge clk);
      #1;
      if (pv) begin
        f  = k / 16;
        kk = k % 16;
        w  = 16 * f + (kk % 4) * 4 + kk / 4;
        check($sformatf("ovf_out[%0d]", k), {11'd0, pl, pd},
              {11'd0, kk == 15, 10'(200 + w), 10'(w)});
        if (k == 15) t15 = cyc;
        if (k == 16) t16 = cyc;
        k++;
      end
      #1;
      cyc++;
    end
    check("ovf_count", 32'(k), 32'd32);
    check("ovf_frame_gap_le1", {31'd0, (t16 - t15) <= 2}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("ovf_in_ready_after", {31'd0, in_ready4}, 32'd1);
    check("ovf_out_valid_after", {31'd0, out_valid4}, 32'd0);
    check("ovf_sticky", {31'd0, overflow4}, 32'd1);
    #1;

    // 80x80: two back-to-back frames in row-FFT burst pattern
    run80(2, 1000);

    // 80x80: reset after 100 outputs, with a partial next frame in the buffer
    exp_q.delete();
    push_frame80(100000);
    fork
      begin
        wr80(100000, 400);
        wr80(300000, 1);
      end
      begin
        drain80(100, 20000, n_out);
      end
    join
    check("rst_mid_count", 32'(n_out), 32'd100);
    @(posedge clk);
    #3;
    check("rst_mid_valid_before", {31'd0, out_valid80}, 32'd1);
    rst80 = 1'b1;
    #1;
    check("rst_mid_out_valid", {31'd0, out_valid80}, 32'd0);
    check("rst_mid_out_data", {12'd0, out_data80}, 32'd0);
    check("rst_mid_out_last", {31'd0, out_last80}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready80}, 32'd1);
    @(posedge clk);
    #2;
    rst80 = 1'b0;
    run80(1, 200000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/transpose_buffer.md
TRANSPOSE_BUFFER -- requirements
Module: transpose_buffer

Interface
REQ-001 Parameter WL, default 10: bits per real/imag component.
REQ-002 Parameter N, default 80: frame is N x N complex samples, written row-major and read column-major.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  sample present on in_r/in_i; driven from the row FFT's done.
REQ-006 in_r  input  WL  real part from the row FFT out_r.
REQ-007 in_i  input  WL  imaginary part from the row FFT out_i.
REQ-008 in_ready  output  1  a bank is writable this cycle.
REQ-009 out_data  output  2*WL  packed {re,im}, matching the column FFT "in" port format.
REQ-010 out_valid  output  1  out_data holds a valid sample.
REQ-011 out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 out_last  output  1  high with the final sample (index N*N-1) of a read frame.
REQ-013 overflow  output  1  sticky flag: an input sample was dropped.

Function
REQ-014 Two banks of N*N words; each bank state is EMPTY, FILLING, FULL or DRAINING.
REQ-015 Write side: in_valid && in_ready stores {in_r,in_i} at wr_cnt in bank wr_bank, then increments wr_cnt.
REQ-016 Bank transitions on write: EMPTY->FILLING on first write; FILLING->FULL on the write at wr_cnt=N*N-1.
REQ-017 After that final write, wr_cnt wraps to 0 and wr_bank toggles.
REQ-018 in_ready = (bank wr_bank is EMPTY or FILLING).
REQ-019 in_valid && !in_ready: sample discarded, overflow set to 1 and held until reset.
REQ-020 Read order: k-th output of a frame = word at address r*N+c, where r = k mod N (inner, fastest) and c = k div N (outer).
REQ-021 Read address generation: add N per step; on r wrap, set address to c+1; no multiplier.
REQ-022 Read side: when bank rd_bank is FULL, it becomes DRAINING and reads start.
REQ-023 RAM read is synchronous; out_data/out_valid are registered.
REQ-024 First out_valid is 2 cycles after the cycle in which the bank became FULL.
REQ-025 Output register loads only when !out_valid || out_ready.
REQ-026 While out_valid && !out_ready, out_data, out_valid and out_last are held stable.
REQ-027 A sample transfers on out_valid && out_ready.
REQ-028 Transfer of the out_last sample sets the bank to EMPTY and toggles rd_bank.
REQ-029 If the next bank is already FULL, its first out_valid follows with no more than 1 idle cycle.
REQ-030 A write completing one bank and a drain completing the other in the same cycle: both transitions take effect.
REQ-031 A bank freed in a cycle is writable (in_ready=1) on the next cycle.
REQ-032 Data path is pure storage: no arithmetic, scaling or reordering of bits within a word.

Reset
REQ-033 rst asserted sets: out_data=0, out_valid=0, out_last=0, overflow=0, in_ready=1.
REQ-034 rst asserted sets: both banks EMPTY; wr_bank=rd_bank=0; all counters 0.
REQ-035 Reset mid-frame abandons both partial frames; RAM contents are not cleared and are never read before being rewritten.

Structure
REQ-036 Shared package fft_pkg holds: WL/N defaults, bank-state enum, address width $clog2(N*N), count width $clog2(N).
REQ-037 Sub-module tp_ram: simple dual-port RAM, depth 2*N*N, width 2*WL, one write port and one synchronous read port.
REQ-038 tp_ram address MSB is the bank bit.
REQ-039 Control counters and FSMs stay in transpose_buffer.

Verification
REQ-040 After reset, no stimulus -> out_valid=0, in_ready=1, out_data=0, overflow=0.
REQ-041 N=4, write 0..15 row-major, out_ready=1 -> outputs 0,4,8,12,1,5,...,11,15; out_last on 15; first out_valid 2 cycles after FULL.
REQ-042 N=4, out_ready pattern 1,0,0,1 repeating -> same output sequence; out_data unchanged on every stalled cycle.
REQ-043 N=4, out_ready=0, stream 48 samples -> in_ready=0 after sample 32; samples 33..48 dropped; overflow=1.
REQ-044 N=80, two 6400-sample frames back-to-back, written in 16-sample bursts every 40 cycles (the row-FFT pattern) -> 12800 outputs, each frame the exact transpose.
REQ-045 N=80, rst pulsed after 100 outputs of frame 1 -> outputs 0 asynchronously; the next written frame is transposed correctly.
